data_memory_responder: RTL and testbench

Memory-side responder for the 256-bit line interface that the data cache drives (enable/write/addr/data out, data/ack back). It holds the backing store of cache lines, accepts one request at a time, waits a fixed latency, then completes the read or write with a single-cycle acknowledge. It is instantiated in the testbench/top next to the CPU. Its ports connect one-to-one to the CPU's `mem_*` ports.

---
 rtl/mem_if_pkg.sv | 15 +
 rtl/line_storage_ram.sv | 39 +++
 rtl/data_memory_responder.sv | 143 ++++++++++++++
 tb/tb_data_memory_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the 256-bit cache-line memory interface.
// This package is used by both the data memory responder and the cache controller.
package mem_if_pkg;

  localparam int LINE_W        = 256;
  localparam int ADDR_W        = 32;
  localparam int LINE_OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } mem_state_e;

endpackage

// File: rtl/line_storage_ram.sv
// Single-port synchronous line store with a registered, read-enabled output.
// The output register clears on reset, but the array contents are not cleared.
module line_storage_ram
  import mem_if_pkg::*;
#(
  parameter int DEPTH_LINES = 512,
  localparam int IDX_W      = $clog2(DEPTH_LINES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_r [DEPTH_LINES];
  logic [LINE_W-1:0] rdata_r;

  // Line array write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_r[idx_i] <= wdata_i;
    end
  end

  // Read register holds its value until the next read is issued
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_r <= '0;
    end else if (re_i) begin
      rdata_r <= mem_r[idx_i];
    end
  end

  assign rdata_o = rdata_r;

endmodule

// File: rtl/data_memory_responder.sv
// Fixed-latency backing store for the data cache line interface.
// It accepts one request at a time and completes it with a single-cycle ack_o.
module data_memory_responder
  import mem_if_pkg::*;
#(
  parameter int LATENCY     = 10,
  parameter int DEPTH_LINES = 512
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  localparam int IDX_W               = $clog2(DEPTH_LINES);
  localparam int CNT_W               = $clog2(LATENCY + 1);
  localparam bit SINGLE_CYCLE        = (LATENCY == 32'sd1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mem_state_e        state_r, state_next_s;
  logic [CNT_W-1:0]  cnt_r, cnt_next_s;
  logic              wr_r;
  logic [IDX_W-1:0]  idx_r;
  logic [LINE_W-1:0] wdata_r;
  logic              ack_r;

  logic              commit_s;
  logic              use_live_s;
  logic              op_write_s;
  logic              ram_we_s;
  logic              ram_re_s;
  logic [IDX_W-1:0]  ram_idx_s;
  logic [LINE_W-1:0] ram_wdata_s;
  logic [IDX_W-1:0]  idx_in_s;
  logic              unused_addr_bits_s;

  // Offset bits and the bits above the line index alias onto the same line
  assign idx_in_s           = addr_i[LINE_OFFSET_W +: IDX_W];
  assign unused_addr_bits_s = ^{addr_i[ADDR_W-1:LINE_OFFSET_W+IDX_W], addr_i[LINE_OFFSET_W-1:0]};

  // Next-state and counter logic; commit_s marks the edge that enters ACK
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    commit_s     = 1'b0;
    use_live_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable_i) begin
          if (SINGLE_CYCLE) begin
            state_next_s = ACK;
            commit_s     = 1'b1;
            use_live_s   = 1'b1;
          end else begin
            state_next_s = BUSY;
            cnt_next_s   = CNT_LOAD;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        cnt_next_s = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          state_next_s = ACK;
          commit_s     = 1'b1;
        end else begin
          state_next_s = BUSY;
        end
      end
      ACK: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // RAM port steering; in a single-cycle build the request goes straight to the RAM
  always_comb begin
    ram_idx_s   = idx_r;
    ram_wdata_s = wdata_r;
    op_write_s  = wr_r;
    if (use_live_s) begin
      ram_idx_s   = idx_in_s;
      ram_wdata_s = data_i;
      op_write_s  = write_i;
    end else begin
      ram_idx_s   = idx_r;
      ram_wdata_s = wdata_r;
      op_write_s  = wr_r;
    end
    ram_we_s = commit_s & op_write_s & ~rst_i;
    ram_re_s = commit_s & ~op_write_s & ~rst_i;
  end

  // Control registers and request capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      ack_r   <= 1'b0;
      wr_r    <= 1'b0;
      idx_r   <= '0;
      wdata_r <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      ack_r   <= (state_next_s == ACK);
      if ((state_r == IDLE) && enable_i) begin
        wr_r    <= write_i;
        idx_r   <= idx_in_s;
        wdata_r <= data_i;
      end else begin
        wr_r    <= wr_r;
        idx_r   <= idx_r;
        wdata_r <= wdata_r;
      end
    end
  end

  line_storage_ram #(
    .DEPTH_LINES (DEPTH_LINES)
  ) u_line_storage_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (ram_we_s),
    .re_i    (ram_re_s),
    .idx_i   (ram_idx_s),
    .wdata_i (ram_wdata_s),
    .rdata_o (data_o)
  );

  assign ack_o = ack_r;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: a LATENCY=10 instance and a LATENCY=1 instance.
module tb_data_memory_responder;
  import mem_if_pkg::*;

  localparam int LAT    = 10;
  localparam int DEPTH  = 512;
  localparam int LAT1   = 1;
  localparam int DEPTH1 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, wr, ack, en1, wr1, ack1;
  logic [31:0]  addr, addr1;
  logic [255:0] wdata, rdata, wdata1, rdata1;

  data_memory_responder #(.LATENCY(LAT), .DEPTH_LINES(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .write_i(wr), .addr_i(addr),
    .data_i(wdata), .ack_o(ack), .data_o(rdata));

  data_memory_responder #(.LATENCY(LAT1), .DEPTH_LINES(DEPTH1)) dut1 (
    .clk_i(clk), .rst_i(rst), .enable_i(en1), .write_i(wr1), .addr_i(addr1),
    .data_i(wdata1), .ack_o(ack1), .data_o(rdata1));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int           ack_cyc;
    logic [255:0] data;
  } exp_t;

  exp_t         sbq[$];
  exp_t         sbq1[$];
  logic [255:0] model_mem  [int];
  logic [255:0] model_mem1 [int];
  logic [255:0] model_last, model_last1;
  bit           written [16];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [31:0] mk_addr(input int idx);
    logic [31:0] a;
    logic [31:0] i;
    a = $urandom();
    i = idx;
    a[13:5] = i[8:0];
    return a;
  endfunction

  // Scoreboard monitors: each ack pops one expected completion
  always @(negedge clk) begin
    exp_t e;
    if (ack === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_ack", 256'd1, 256'd0);
      end else begin
        e = sbq.pop_front();
        check("ack_cycle", cyc, e.ack_cyc);
        check("data_o", rdata, e.data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ack1 === 1'b1) begin
      if (sbq1.size() == 0) begin
        check("l1_unexpected_ack", 256'd1, 256'd0);
      end else begin
        e = sbq1.pop_front();
        check("l1_ack_cycle", cyc, e.ack_cyc);
        check("l1_data_o", rdata1, e.data);
      end
    end
  end

  // Drive a request at the current negedge; extra = idle edges before acceptance
  task automatic issue(input int sel, input logic w, input logic [31:0] a,
                       input logic [255:0] d, input int extra);
    exp_t e;
    int   i;
    if (sel == 0) begin
      en = 1'b1; wr = w; addr = a; wdata = d;
      i = int'((a >> 5) % DEPTH);
      if (w) begin
        model_mem[i] = d;
        e.data = model_last;
      end else begin
        e.data = model_mem[i];
        model_last = e.data;
      end
      e.ack_cyc = cyc + LAT + extra;
      sbq.push_back(e);
    end else begin
      en1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d;
      i = int'((a >> 5) % DEPTH1);
      if (w) begin
        model_mem1[i] = d;
        e.data = model_last1;
      end else begin
        e.data = model_mem1[i];
        model_last1 = e.data;
      end
      e.ack_cyc = cyc + LAT1 + extra;
      sbq1.push_back(e);
    end
  endtask

  task automatic wait_ack(input int sel, input bit churn, input bit keep_en);
    int lim;
    lim = (sel == 0) ? LAT + 4 : LAT1 + 4;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (((sel == 0) ? ack : ack1) === 1'b1) begin
        if (!keep_en) begin
          if (sel == 0) en = 1'b0; else en1 = 1'b0;
        end
        return;
      end
      if (churn && sel == 0) begin
        en = 1'b0; wr = 1'($urandom()); addr = $urandom(); wdata = rand256();
      end
    end
    check("ack_timeout", 256'd0, 256'd1);
    en = 1'b0; en1 = 1'b0;
  endtask

  task automatic op(input int sel, input logic w, input logic [31:0] a,
                    input logic [255:0] d, input bit churn);
    @(negedge clk);
    issue(sel, w, a, d, 0);
    wait_ack(sel, churn, 1'b0);
  endtask

  task automatic expect_no_ack(input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      if (ack === 1'b1) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] p, q, r;
    int           idx, acc;
    logic         w;
    rst = 1'b1; en = 1'b0; wr = 1'b0; addr = 32'd0; wdata = '0;
    en1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0; wdata1 = '0;
    model_last = '0; model_last1 = '0;
    repeat (3) @(negedge clk);
    check("reset_ack", ack, 1'b0);
    check("reset_data_o", rdata, 256'd0);
    check("l1_reset_ack", ack1, 1'b0);
    check("l1_reset_data_o", rdata1, 256'd0);
    rst = 1'b0;

    // Write then read
    op(0, 1'b1, 32'h0000_0400, {32{8'hA5}}, 1'b0);
    op(0, 1'b0, 32'h0000_0400, '0, 1'b0);

    // Offset and aliasing
    p = rand256();
    op(0, 1'b1, 32'h0000_0420, p, 1'b0);
    op(0, 1'b0, 32'h0000_043F, '0, 1'b0);
    op(0, 1'b0, 32'h0000_0420 + 32'(512 * 32), '0, 1'b0);
    op(0, 1'b0, 32'h0000_0400, '0, 1'b0);

    // Back-to-back reads with enable held high
    @(negedge clk);
    issue(0, 1'b0, 32'h0000_0420, '0, 0);
    wait_ack(0, 1'b0, 1'b1);
    issue(0, 1'b0, 32'h0000_0400, '0, 1);
    wait_ack(0, 1'b0, 1'b0);

    // Input churn during BUSY
    op(0, 1'b1, 32'h0000_00E0, rand256(), 1'b1);
    op(0, 1'b0, 32'h0000_00E0, '0, 1'b1);

    // Reset five edges into a write of line 3
    q = rand256();
    r = ~q;
    op(0, 1'b1, 32'h0000_0060, q, 1'b0);
    op(0, 1'b0, 32'h0000_0060, '0, 1'b0);
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = 32'h0000_0060; wdata = r;
    acc = cyc + 1;
    while (cyc < acc + 4) @(negedge clk);
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_last = '0;
    check("abort_data_o", rdata, 256'd0);
    expect_no_ack("abort_no_ack");
    op(0, 1'b0, 32'h0000_0060, '0, 1'b0);

    // Enable and reset on the same edge
    @(negedge clk);
    rst = 1'b1; en = 1'b1; wr = 1'b1; addr = 32'h0000_0060; wdata = r;
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    model_last = '0; model_last1 = '0;
    expect_no_ack("rst_en_no_ack");
    op(0, 1'b0, 32'h0000_0060, '0, 1'b0);

    // Randomized traffic over a small pool of lines
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(15, 0);
      w = !written[idx] || ($urandom_range(1, 0) == 1);
      written[idx] = 1'b1;
      op(0, w, mk_addr(idx), rand256(), 1'($urandom()));
    end

    // LATENCY=1 instance
    p = rand256();
    op(1, 1'b1, 32'h0000_00A0, p, 1'b0);
    op(1, 1'b0, 32'h0000_00A0, '0, 1'b0);
    op(1, 1'b0, 32'h0000_00A0 + 32'(16 * 32), '0, 1'b0);
    op(1, 1'b1, 32'h0000_0040, rand256(), 1'b0);
    @(negedge clk);
    issue(1, 1'b0, 32'h0000_0040, '0, 0);
    wait_ack(1, 1'b0, 1'b1);
    issue(1, 1'b0, 32'h0000_00A0, '0, 1);
    wait_ack(1, 1'b0, 1'b0);

    repeat (LAT + 3) @(negedge clk);
    check("sb_drained", sbq.size(), 0);
    check("l1_sb_drained", sbq1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
